// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing for the memory arbiter: state encoding, block geometry
// and the word counter type used by the fill sequencer.
package mem_arbiter_pkg;
  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned WORDS_PER_BLK = 8;
  localparam int unsigned MEM_LAT       = 4;
  localparam int unsigned BLK_OFFSET_W  = $clog2(WORDS_PER_BLK * 2);
  localparam int unsigned CNT_W         = $clog2(WORDS_PER_BLK);
  localparam int unsigned BLK_W         = ADDR_W - BLK_OFFSET_W;

  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} arb_state_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_LAST = cnt_t'(WORDS_PER_BLK - 1);
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache/memory side signals of the arbiter; master is the arbiter, slave is the
// caches plus memory.
interface mem_arbiter_if import mem_arbiter_pkg::*; ();
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_data_valid;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] fill_data;
  cnt_t              fill_word;
  logic              i_fill_we;
  logic              d_fill_we;
  logic              i_fill_done;
  logic              d_fill_done;
  logic              d_wr_done;
  logic              i_busy;
  logic              d_busy;

  modport master (
    input  i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data,
           mem_data_in, mem_data_valid,
    output mem_en, mem_wr, mem_addr, mem_data_out, fill_data, fill_word,
           i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, i_busy, d_busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data,
           mem_data_in, mem_data_valid,
    input  mem_en, mem_wr, mem_addr, mem_data_out, fill_data, fill_word,
           i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, i_busy, d_busy
  );
endinterface

// File: rtl/mem_arbiter_fill_seq.sv
// Block fill sequencer: issues one word address per cycle, counts returned words
// and flags the last one. Shared by the I and D fill states.
module mem_arbiter_fill_seq
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              active,
  input  logic              data_valid,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              issue_en,
  output logic [ADDR_W-1:0] issue_addr,
  output logic              rx_we,
  output cnt_t              rx_word,
  output logic              done
);
  logic [BLK_W-1:0] blk_q, blk_d, blk_cur;
  cnt_t             issue_cnt_q, issue_cnt_d, rx_cnt_q, rx_cnt_d, issue_idx;
  logic             issuing_q, issuing_d;

  always_comb begin
    blk_d       = blk_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    issuing_d   = issuing_q;

    // Word 0 goes out in the grant cycle straight from the requester's address.
    blk_cur    = start ? start_addr[ADDR_W-1:BLK_OFFSET_W] : blk_q;
    issue_idx  = start ? '0 : issue_cnt_q;
    issue_en   = start | (active & issuing_q);
    issue_addr = issue_en ? {blk_cur, issue_idx, 1'b0} : '0;

    rx_we   = active & data_valid;
    rx_word = rx_we ? rx_cnt_q : '0;
    done    = rx_we & (rx_cnt_q == CNT_LAST);

    if (start) begin
      blk_d       = start_addr[ADDR_W-1:BLK_OFFSET_W];
      issue_cnt_d = cnt_t'(1);
      issuing_d   = 1'b1;
      rx_cnt_d    = '0;
    end else if (issue_en) begin
      issue_cnt_d = issue_cnt_q + 1'b1;
      issuing_d   = (issue_cnt_q != CNT_LAST);
    end
    if (rx_we) rx_cnt_d = rx_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q       <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      issuing_q   <= 1'b0;
    end else begin
      blk_q       <= blk_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      issuing_q   <= issuing_d;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared main memory between I-cache fills, D-cache fills and
// D-cache write-through stores, steering returned words to the granted cache.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.master bus
);
  arb_state_t        state_q, state_d, cur;
  logic              fill_start, fill_active, issue_en, rx_we, done;
  logic [ADDR_W-1:0] issue_addr, start_addr;
  cnt_t              rx_word;

  // IDLE decides and acts in the same cycle: cur is the state being served now,
  // so a store or first fill address leaves in the cycle the grant is made.
  always_comb begin
    cur = state_q;
    if (rst) begin
      cur = IDLE;
    end else if (state_q == IDLE) begin
      if (bus.d_wr_req)   cur = WRITE;
      else if (bus.d_req) cur = FILL_D;
      else if (bus.i_req) cur = FILL_I;
    end

    fill_start  = (state_q == IDLE) && (cur == FILL_I || cur == FILL_D);
    fill_active = (state_q == FILL_I || state_q == FILL_D) && !rst;
    start_addr  = (cur == FILL_D) ? bus.d_addr : bus.i_addr;

    case (cur)
      FILL_I, FILL_D: state_d = done ? IDLE : cur;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  mem_arbiter_fill_seq u_fill_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (fill_start),
    .active     (fill_active),
    .data_valid (bus.mem_data_valid),
    .start_addr (start_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rx_we      (rx_we),
    .rx_word    (rx_word),
    .done       (done)
  );

  always_comb begin
    bus.mem_en       = (cur == WRITE) | issue_en;
    bus.mem_wr       = (cur == WRITE);
    bus.mem_addr     = (cur == WRITE) ? bus.d_wr_addr : issue_addr;
    bus.mem_data_out = (cur == WRITE) ? bus.d_wr_data : '0;
    bus.fill_data    = rx_we ? bus.mem_data_in : '0;
    bus.fill_word    = rx_word;
    bus.i_fill_we    = rx_we & (state_q == FILL_I);
    bus.d_fill_we    = rx_we & (state_q == FILL_D);
    bus.i_fill_done  = done & (state_q == FILL_I);
    bus.d_fill_done  = done & (state_q == FILL_D);
    bus.d_wr_done    = (cur == WRITE);
    bus.i_busy       = !rst & (bus.i_req | (cur == FILL_I));
    bus.d_busy       = !rst & (bus.d_req | bus.d_wr_req | (cur == WRITE) | (cur == FILL_D));
  end
endmodule
